// File: rtl/bip_uart_top.sv
// BIP-I system top: built-in program ROM, data RAM, single-cycle accumulator
// CPU and an 8N1 UART transmitter. The CPU runs from reset until it executes
// HLT. The six-byte status report (ACC, PC, CYC) is then shifted out on TX,
// and the block parks in DONE with the line idle until the next reset.
//
// PROGRAM selects the ROM image: 0 = default program, 1 = sign-extension
// check (LDI -1, ADDI 1, HLT), 2 = accumulator wrap check (LDI 0x3FF, STO 2,
// 63 x ADD 2, HLT).
module bip_uart_top #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PM_ADDR_W    = 11,
  parameter int DM_ADDR_W    = 10,
  parameter int PROGRAM      = 0
) (
  input  logic CLK,
  input  logic RESET,
  output logic TX
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int DM_DEPTH = 1 << DM_ADDR_W;

  // ROM image, addressed by PC; every word not listed reads as HLT.
  function automatic logic [15:0] rom_word(input logic [PM_ADDR_W-1:0] a);
    logic [15:0] w;
    w = 16'h0000;
    case (PROGRAM)
      32'd1: begin
        case (a)
          PM_ADDR_W'(0): w = 16'h1FFF;  // LDI 0x7FF (-1)
          PM_ADDR_W'(1): w = 16'h2801;  // ADDI 1
          default:       w = 16'h0000;  // HLT
        endcase
      end
      32'd2: begin
        if (a == PM_ADDR_W'(0)) begin
          w = 16'h1BFF;                 // LDI 0x3FF
        end else if (a == PM_ADDR_W'(1)) begin
          w = 16'h0802;                 // STO 2
        end else if ((a >= PM_ADDR_W'(2)) && (a <= PM_ADDR_W'(64))) begin
          w = 16'h2002;                 // ADD 2
        end else begin
          w = 16'h0000;                 // HLT
        end
      end
      default: begin
        case (a)
          PM_ADDR_W'(0): w = 16'h1805;  // LDI 5
          PM_ADDR_W'(1): w = 16'h0800;  // STO 0
          PM_ADDR_W'(2): w = 16'h1803;  // LDI 3
          PM_ADDR_W'(3): w = 16'h2000;  // ADD 0
          PM_ADDR_W'(4): w = 16'h3801;  // SUBI 1
          PM_ADDR_W'(5): w = 16'h0801;  // STO 1
          PM_ADDR_W'(6): w = 16'h1001;  // LD 1
          default:       w = 16'h0000;  // HLT
        endcase
      end
    endcase
    return w;
  endfunction

  state_t                 state_r;
  logic [PM_ADDR_W-1:0]   pc_r;
  logic [15:0]            acc_r;
  logic [15:0]            cyc_r;
  logic                   tx_r;
  logic [BAUD_W-1:0]      baud_cnt_r;
  logic [3:0]             bit_idx_r;   // 0 start, 1..8 data, 9 stop
  logic [2:0]             byte_idx_r;  // report byte 0..5

  logic [15:0]            dm_mem [DM_DEPTH];

  logic [15:0]            instr_s;
  logic [4:0]             opcode_s;
  logic [10:0]            operand_s;
  logic [15:0]            imm_s;
  logic [DM_ADDR_W-1:0]   dm_addr_s;
  logic [15:0]            dm_rdata_s;
  logic [15:0]            acc_next_s;
  logic                   dm_we_s;
  logic                   halt_s;
  logic [15:0]            pc_ext_s;
  logic [7:0]             report_byte_s;

  assign instr_s    = rom_word(pc_r);
  assign opcode_s   = instr_s[15:11];
  assign operand_s  = instr_s[10:0];
  assign imm_s      = {{5{operand_s[10]}}, operand_s};
  assign dm_addr_s  = operand_s[DM_ADDR_W-1:0];
  assign dm_rdata_s = dm_mem[dm_addr_s];
  assign halt_s     = (opcode_s == OP_HLT);
  assign dm_we_s    = (state_r == ST_RUN) && (opcode_s == OP_STO);
  assign pc_ext_s   = 16'(pc_r);
  assign TX         = tx_r;

  // Accumulator result of the instruction at PC; unknown opcodes keep ACC.
  always_comb begin
    acc_next_s = acc_r;
    case (opcode_s)
      OP_LD:   acc_next_s = dm_rdata_s;
      OP_LDI:  acc_next_s = imm_s;
      OP_ADD:  acc_next_s = acc_r + dm_rdata_s;
      OP_ADDI: acc_next_s = acc_r + imm_s;
      OP_SUB:  acc_next_s = acc_r - dm_rdata_s;
      OP_SUBI: acc_next_s = acc_r - imm_s;
      default: acc_next_s = acc_r;
    endcase
  end

  // Report byte currently being framed, taken from the frozen CPU state.
  always_comb begin
    report_byte_s = 8'h00;
    case (byte_idx_r)
      3'd0:    report_byte_s = acc_r[15:8];
      3'd1:    report_byte_s = acc_r[7:0];
      3'd2:    report_byte_s = pc_ext_s[15:8];
      3'd3:    report_byte_s = pc_ext_s[7:0];
      3'd4:    report_byte_s = cyc_r[15:8];
      3'd5:    report_byte_s = cyc_r[7:0];
      default: report_byte_s = 8'h00;
    endcase
  end

  // Data RAM: synchronous write from STO, contents not reset.
  always_ff @(posedge CLK) begin
    if (dm_we_s) begin
      dm_mem[dm_addr_s] <= acc_r;
    end
  end

  // Control FSM: execute until HLT, shift out the report, then idle forever.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_RUN;
      pc_r       <= '0;
      acc_r      <= 16'h0000;
      cyc_r      <= 16'h0000;
      tx_r       <= 1'b1;
      baud_cnt_r <= '0;
      bit_idx_r  <= 4'd0;
      byte_idx_r <= 3'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          cyc_r <= cyc_r + 16'd1;
          if (halt_s) begin
            // PC and ACC freeze; the first start bit goes out right away.
            state_r    <= ST_SEND;
            tx_r       <= 1'b0;
            baud_cnt_r <= '0;
            bit_idx_r  <= 4'd0;
            byte_idx_r <= 3'd0;
          end else begin
            pc_r  <= pc_r + PM_ADDR_W'(1);
            acc_r <= acc_next_s;
          end
        end
        ST_SEND: begin
          if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 4'd9) begin
              if (byte_idx_r == 3'd5) begin
                state_r <= ST_DONE;
                tx_r    <= 1'b1;
              end else begin
                // Next frame's start bit follows the stop bit directly.
                byte_idx_r <= byte_idx_r + 3'd1;
                bit_idx_r  <= 4'd0;
                tx_r       <= 1'b0;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
              if (bit_idx_r == 4'd8) begin
                tx_r <= 1'b1;
              end else begin
                tx_r <= report_byte_s[bit_idx_r[2:0]];
              end
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        ST_DONE: begin
          tx_r <= 1'b1;
        end
        default: begin
          state_r <= ST_DONE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_uart_top.sv
// Directed bench for bip_uart_top: three instances, one per ROM image, each
// with its own reset. TX is decoded cycle-accurately with CLKS_PER_BIT = 16.
module tb_bip_uart_top;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_def, rst_neg, rst_wrap;
  logic tx_def, tx_neg, tx_wrap;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  logic [7:0] rep_bytes [6];
  int         rep_starts [6];
  bit         rep_ok;

  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  bip_uart_top #(.CLKS_PER_BIT(CPB), .PM_ADDR_W(11), .DM_ADDR_W(10), .PROGRAM(0))
    u_def (.CLK(clk), .RESET(rst_def), .TX(tx_def));
  bip_uart_top #(.CLKS_PER_BIT(CPB), .PM_ADDR_W(11), .DM_ADDR_W(10), .PROGRAM(1))
    u_neg (.CLK(clk), .RESET(rst_neg), .TX(tx_neg));
  bip_uart_top #(.CLKS_PER_BIT(CPB), .PM_ADDR_W(11), .DM_ADDR_W(10), .PROGRAM(2))
    u_wrap (.CLK(clk), .RESET(rst_wrap), .TX(tx_wrap));

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx_def;
      1:       return tx_neg;
      default: return tx_wrap;
    endcase
  endfunction

  // Receive one frame: find the start bit (bounded), sample each bit mid-way.
  task automatic rx_byte(input int sel, output logic [7:0] data,
                         output int start_cyc, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    data = 8'h00;
    start_cyc = 0;
    while (tx_of(sel) !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) begin
      ok = 1'b0;
      return;
    end
    start_cyc = cycles;
    repeat (CPB / 2) @(negedge clk);
    if (tx_of(sel) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      data[i] = tx_of(sel);
    end
    repeat (CPB) @(negedge clk);
    if (tx_of(sel) !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_report(input int sel);
    logic [7:0] b;
    int         s;
    bit         ok;
    rep_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rep_bytes[i]  = 8'hxx;
      rep_starts[i] = 0;
    end
    for (int i = 0; i < 6; i++) begin
      rx_byte(sel, b, s, ok);
      rep_bytes[i]  = b;
      rep_starts[i] = s;
      if (!ok) begin
        rep_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_def = 1'b1; rst_neg = 1'b1; rst_wrap = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (tx_def !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_def); end
    checks++; if (u_def.pc_r !== 11'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", u_def.pc_r); end
    checks++; if (u_def.acc_r !== 16'h0000) begin errors++; $display("FAIL reset_acc got %h want 0000", u_def.acc_r); end
    checks++; if (u_def.cyc_r !== 16'h0000) begin errors++; $display("FAIL reset_cyc got %h want 0000", u_def.cyc_r); end
    checks++; if (tx_neg !== 1'b1 || tx_wrap !== 1'b1) begin errors++; $display("FAIL reset_tx_others got %b%b want 11", tx_neg, tx_wrap); end
  endtask

  // PC walks 0..7 one per clock, then stays at the HLT address.
  task automatic test_pc_step(output int rel);
    rst_def = 1'b0;
    rel = cycles;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (u_def.pc_r !== 11'((k <= 7) ? k : 7)) begin
        errors++; $display("FAIL pc_step k=%0d got %0d want %0d", k, u_def.pc_r, (k <= 7) ? k : 7);
      end
    end
  endtask

  task automatic test_default_program();
    checks++; if (u_def.acc_r !== 16'h0007) begin errors++; $display("FAIL def_acc got %h want 0007", u_def.acc_r); end
    checks++; if (u_def.dm_mem[0] !== 16'h0005) begin errors++; $display("FAIL def_dm0 got %h want 0005", u_def.dm_mem[0]); end
    checks++; if (u_def.dm_mem[1] !== 16'h0007) begin errors++; $display("FAIL def_dm1 got %h want 0007", u_def.dm_mem[1]); end
    checks++; if (u_def.cyc_r !== 16'h0008) begin errors++; $display("FAIL def_cyc got %h want 0008", u_def.cyc_r); end
  endtask

  task automatic test_report(input int sel, input int rel, input int hlt_cyc,
                             input logic [47:0] expect_rep, input string tag);
    logic [7:0] eb;
    rx_report(sel);
    checks++; if (rep_ok !== 1'b1) begin errors++; $display("FAIL %s_frames got framing/timeout error want 6 clean frames", tag); end
    for (int i = 0; i < 6; i++) begin
      eb = expect_rep[47 - 8*i -: 8];
      checks++;
      if (rep_bytes[i] !== eb) begin
        errors++; $display("FAIL %s_byte%0d got %h want %h", tag, i, rep_bytes[i], eb);
      end
    end
    checks++;
    if (rep_starts[0] - rel !== hlt_cyc) begin
      errors++; $display("FAIL %s_first_start got %0d want %0d", tag, rep_starts[0] - rel, hlt_cyc);
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (rep_starts[i] - rep_starts[i-1] !== 10 * CPB) begin
        errors++; $display("FAIL %s_frame_len%0d got %0d want %0d", tag, i, rep_starts[i] - rep_starts[i-1], 10 * CPB);
      end
    end
  endtask

  // After the last stop bit the line stays idle and state stays frozen.
  task automatic test_done_idle();
    int lows;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx_def !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL done_idle got %0d low cycles want 0", lows); end
    checks++; if (u_def.pc_r !== 11'd7) begin errors++; $display("FAIL done_pc got %0d want 7", u_def.pc_r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int         s;
    bit         ok;
    int         rel;
    rst_def = 1'b1;
    repeat (3) @(negedge clk);
    rst_def = 1'b0;
    rx_byte(0, b, s, ok);
    checks++; if (!ok || b !== 8'h00) begin errors++; $display("FAIL midrst_frame1 got %h ok=%0d want 00 ok=1", b, ok); end
    // Land inside data bit 4 of the second frame (0x07 -> that bit is 0).
    repeat (8 + 88) @(negedge clk);
    checks++; if (tx_def !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx got %b want 0", tx_def); end
    rst_def = 1'b1;
    #1;
    checks++; if (tx_def !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx_def); end
    checks++; if (u_def.pc_r !== 11'd0 || u_def.acc_r !== 16'h0000 || u_def.cyc_r !== 16'h0000) begin
      errors++; $display("FAIL midrst_state got pc=%0d acc=%h cyc=%h want 0 0000 0000", u_def.pc_r, u_def.acc_r, u_def.cyc_r);
    end
    repeat (3) @(negedge clk);
    rst_def = 1'b0;
    rel = cycles;
    test_report(0, rel, 8, 48'h0007_0007_0008, "replay");
  endtask

  task automatic test_negative_immediate();
    int rel;
    rst_neg = 1'b0;
    rel = cycles;
    test_report(1, rel, 3, 48'h0000_0002_0003, "neg");
    checks++; if (u_neg.acc_r !== 16'h0000) begin errors++; $display("FAIL neg_acc got %h want 0000", u_neg.acc_r); end
    checks++; if (u_neg.cyc_r !== 16'h0003) begin errors++; $display("FAIL neg_cyc got %h want 0003", u_neg.cyc_r); end
  endtask

  task automatic test_wrap();
    int rel;
    rst_wrap = 1'b0;
    rel = cycles;
    test_report(2, rel, 66, 48'hFFC0_0041_0042, "wrap");
    checks++; if (u_wrap.acc_r !== 16'hFFC0) begin errors++; $display("FAIL wrap_acc got %h want ffc0", u_wrap.acc_r); end
    checks++; if (u_wrap.dm_mem[2] !== 16'h03FF) begin errors++; $display("FAIL wrap_dm2 got %h want 03ff", u_wrap.dm_mem[2]); end
  endtask

  initial begin
    int rel;
    test_reset();
    test_pc_step(rel);
    test_default_program();
    test_report(0, rel, 8, 48'h0007_0007_0008, "def");
    test_done_idle();
    test_reset_mid_frame();
    test_negative_immediate();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
